apb_rr_arbiter: RTL and testbench

//  Shares one APB master port among NUM_REQ command requesters using round-robin arbitration.

---
 rtl/apb_arb_pkg.sv | 19 +
 rtl/apb_rr_arbiter_rr_pick.sv | 34 +++
 rtl/apb_rr_arbiter.sv | 109 ++++++++++
 tb/tb_apb_rr_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and command encodings for the round-robin APB arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_RD   = 2'b01;
  localparam logic [1:0] CMD_WR   = 2'b10;

  // 2'b11 is reserved and behaves like CMD_IDLE
  function automatic logic cmd_valid(input logic [1:0] cmd);
    return (cmd == CMD_RD) || (cmd == CMD_WR);
  endfunction

endpackage

// File: rtl/apb_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid requester after 'last', wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_valid
);

  int               pos;
  logic [IDX_W-1:0] pidx;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    pos       = 0;
    pidx      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      pos = int'(last) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pidx = IDX_W'(pos);
      if (!any_valid && valid[pidx]) begin
        any_valid       = 1'b1;
        grant_idx       = pidx;
        grant_oh[pidx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB master among NUM_REQ command requesters.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0][1:0]         req_cmd_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_wdata_i,
  output logic [NUM_REQ-1:0]              req_done_o,
  output logic [DATA_W-1:0]               req_rdata_o,
  output logic                            req_err_o,
  output logic                            psel_o,
  output logic                            penable_o,
  output logic [ADDR_W-1:0]               paddr_o,
  output logic                            pwrite_o,
  output logic [DATA_W-1:0]               pwdata_o,
  input  logic                            pready_i,
  input  logic [DATA_W-1:0]               prdata_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     last;
  logic [NUM_REQ-1:0]   grant_oh;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   pick_oh;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic                 timeout_hit;
  logic                 complete;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) req_valid[i] = cmd_valid(req_cmd_i[i]);
  end

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .valid     (req_valid),
    .last      (last),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx),
    .any_valid (pick_any)
  );

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;

  // Counts consecutive stalled ACCESS cycles of the current transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            to_cnt <= '0;
    else if (state == SETUP)              to_cnt <= '0;
    else if (state == ACCESS && !pready_i) to_cnt <= to_cnt + 1'b1;
  end

  assign timeout_hit = (state == ACCESS) && !pready_i &&
                       (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign complete = (state == ACCESS) && (pready_i || timeout_hit);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (complete) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant and payload are captured once, in the IDLE cycle that arbitrates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last     <= IDX_W'(NUM_REQ - 1);
      grant_oh <= '0;
      paddr_o  <= '0;
      pwdata_o <= '0;
      pwrite_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_any) begin
        last     <= pick_idx;
        grant_oh <= pick_oh;
        paddr_o  <= req_addr_i[pick_idx];
        pwdata_o <= req_wdata_i[pick_idx];
        pwrite_o <= (req_cmd_i[pick_idx] == CMD_WR);
      end
    end
  end

  assign psel_o      = (state != IDLE);
  assign penable_o   = (state == ACCESS);
  assign req_done_o  = complete ? grant_oh : '0;
  assign req_err_o   = timeout_hit;
  assign req_rdata_o = prdata_i;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Randomized scoreboard bench for apb_rr_arbiter; honours APB_TIMEOUT_EN when defined.
module tb_apb_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TO      = 16;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0][1:0]        req_cmd;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             done;
  logic [DATA_W-1:0]              rdata;
  logic                           err, psel, penable, pwrite, pready;
  logic [ADDR_W-1:0]              paddr;
  logic [DATA_W-1:0]              pwdata, prdata;

  apb_rr_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_cmd_i   (req_cmd),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_done_o  (done),
    .req_rdata_o (rdata),
    .req_err_o   (err),
    .psel_o      (psel),
    .penable_o   (penable),
    .paddr_o     (paddr),
    .pwrite_o    (pwrite),
    .pwdata_o    (pwdata),
    .pready_i    (pready),
    .prdata_i    (prdata)
  );

  typedef struct {
    int                idx;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    bit                wr;
    bit                err;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_en = 1'b0;
  bit   exp_psel = 1'b0, exp_pen = 1'b0, exp_done = 1'b0;
  int   m_phase = 0;            // 0 idle, 1 setup, 2 access
  int   m_last = NUM_REQ - 1;
  int   m_acc = 0;
  int   m_wait = 0;
  int   p_new = 30;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit is_valid(input logic [1:0] c);
    return (c == 2'b01) || (c == 2'b10);
  endfunction

  task automatic new_cmd(input int i, input bit force_valid);
    int r;
    r = $urandom_range(0, 99);
    if (force_valid) req_cmd[i] = (r < 50) ? 2'b01 : 2'b10;
    else if (r < 40) req_cmd[i] = 2'b01;
    else if (r < 80) req_cmd[i] = 2'b10;
    else if (r < 90) req_cmd[i] = 2'b00;
    else             req_cmd[i] = 2'b11;
    req_addr[i]  = $urandom;
    req_wdata[i] = $urandom;
  endtask

  // Monitor: compares every DUT completion against the oldest expected one
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      check("psel", 64'(psel), 64'(exp_psel));
      check("penable", 64'(penable), 64'(exp_pen));
      check("done_present", 64'(|done), 64'(exp_done));
      if (|done) begin
        if (sb.size() == 0) check("unexpected_done", 64'(done), 64'(0));
        else begin
          e = sb.pop_front();
          check("done_onehot", 64'(done), 64'(1) << e.idx);
          check("paddr", 64'(paddr), 64'(e.addr));
          check("pwrite", 64'(pwrite), 64'(e.wr));
          check("err", 64'(err), 64'(e.err));
          if (e.wr) check("pwdata", 64'(pwdata), 64'(e.wdata));
          else      check("rdata", 64'(rdata), 64'(e.rdata));
        end
      end else begin
        check("err_quiet", 64'(err), 64'(0));
      end
    end
  end

  // One clock of the reference model: advance from last cycle, then drive this cycle
  task automatic step();
    bit completed;
    int r;
    @(posedge clk);
    #1;
    completed = 1'b0;
    case (m_phase)
      0: begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          int g;
          g = (m_last + k) % NUM_REQ;
          if (is_valid(req_cmd[g])) begin
            m_last    = g;
            cur.idx   = g;
            cur.addr  = req_addr[g];
            cur.wdata = req_wdata[g];
            cur.wr    = (req_cmd[g] == 2'b10);
            cur.rdata = $urandom;
            r = $urandom_range(0, 99);
            if (r < 70)                 m_wait = $urandom_range(0, 2);
            else if (r < 85 || !TO_EN)  m_wait = $urandom_range(3, 6);
            else if (r < 92)            m_wait = TO - 1;
            else                        m_wait = TO + 5;
            cur.err = TO_EN && (m_wait >= TO);
            sb.push_back(cur);
            m_phase = 1;
            break;
          end
        end
      end
      1: begin
        m_phase = 2;
        m_acc   = 0;
      end
      default: if (exp_done) begin
        m_phase   = 0;
        completed = 1'b1;
      end
    endcase

    if (completed) begin
      if ($urandom_range(0, 99) < p_new) new_cmd(cur.idx, p_new == 100);
      else req_cmd[cur.idx] = 2'b00;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!is_valid(req_cmd[i]) && !(m_phase != 0 && i == cur.idx) &&
          $urandom_range(0, 99) < p_new)
        new_cmd(i, p_new == 100);
    end
    // A granted requester may withdraw; its latched transfer must still finish
    if (m_phase != 0 && $urandom_range(0, 99) < 5) req_cmd[cur.idx] = 2'b00;

    exp_done = 1'b0;
    pready   = 1'($urandom_range(0, 1));
    prdata   = $urandom;
    if (m_phase == 2) begin
      m_acc++;
      pready = (m_acc > m_wait);
      if (pready) prdata = cur.rdata;
      exp_done = pready || (TO_EN && m_acc == TO);
    end
    exp_psel = (m_phase != 0);
    exp_pen  = (m_phase == 2);
  endtask

  task automatic reset_mid();
    chk_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_async_psel", 64'(psel), 64'(0));
    check("rst_async_penable", 64'(penable), 64'(0));
    check("rst_async_done", 64'(done), 64'(0));
    @(posedge clk);
    #1;
    reset    = 1'b0;
    sb.delete();
    m_phase  = 0;
    m_last   = NUM_REQ - 1;
    exp_done = 1'b0;
    exp_psel = 1'b0;
    exp_pen  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) new_cmd(i, 1'b1);
    chk_en = 1'b1;
  endtask

  initial begin
    bit want_rst;
    req_cmd   = '0;
    req_addr  = '0;
    req_wdata = '0;
    pready    = 1'b0;
    prdata    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_psel", 64'(psel), 64'(0));
    check("reset_penable", 64'(penable), 64'(0));
    check("reset_pwrite", 64'(pwrite), 64'(0));
    check("reset_paddr", 64'(paddr), 64'(0));
    check("reset_pwdata", 64'(pwdata), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_err", 64'(err), 64'(0));

    // Everybody requests at once: requester 0 must win first
    for (int i = 0; i < NUM_REQ; i++) new_cmd(i, 1'b1);
    reset  = 1'b0;
    chk_en = 1'b1;

    want_rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      p_new = (n >= 1000 && n < 1600) ? 100 : 30;
      step();
      if (n % 500 == 250) want_rst = 1'b1;
      if (want_rst && m_phase == 2 && !exp_done) begin
        want_rst = 1'b0;
        reset_mid();
      end
    end

    p_new = 0;
    repeat (300) step();
    check("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
